// File: rtl/bcd_counter_pkg.sv
// Shared constants and helpers for the prescaled BCD tick counter.
// Optional down counting is enabled by BCD_TICK_COUNTER_DOWN_EN.
package bcd_counter_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX  = 4'd9;
  localparam logic [BCD_W-1:0] BCD_ZERO = 4'd0;

  // Width needed to hold 0..value-1, never less than one bit.
  function automatic int clog2(input int unsigned value);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((longint'(1) << i) < longint'(value)) w = i + 1;
    end
    return w;
  endfunction

  // Any value of 9 or above steps to 0 so stray codes self-heal.
  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] d);
    return (d >= BCD_MAX) ? BCD_ZERO : d + 4'd1;
  endfunction

  function automatic logic [BCD_W-1:0] bcd_dec(input logic [BCD_W-1:0] d);
    return (d == BCD_ZERO) ? BCD_MAX : d - 4'd1;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade cell: steps on inc, flags its terminal value on c_out.
// Down counting (dn port) exists only with BCD_TICK_COUNTER_DOWN_EN.
module bcd_digit
  import bcd_counter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
`ifdef BCD_TICK_COUNTER_DOWN_EN
  input  logic             dn,
`endif
  output logic [BCD_W-1:0] digit,
  output logic             c_out
);

  logic [BCD_W-1:0] digit_q;
  logic [BCD_W-1:0] digit_d;

  always_comb begin
    digit_d = digit_q;
`ifdef BCD_TICK_COUNTER_DOWN_EN
    c_out = dn ? (digit_q == BCD_ZERO) : (digit_q >= BCD_MAX);
    if (clr) begin
      digit_d = BCD_ZERO;
    end else if (inc) begin
      digit_d = dn ? bcd_dec(digit_q) : bcd_inc(digit_q);
    end
`else
    c_out = (digit_q >= BCD_MAX);
    if (clr) begin
      digit_d = BCD_ZERO;
    end else if (inc) begin
      digit_d = bcd_inc(digit_q);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digit_q <= BCD_ZERO;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;

endmodule

// File: rtl/bcd_tick_counter.sv
// Enabled prescaler feeding a DIGITS-decade BCD counter with tick/carry pulses.
// Define BCD_TICK_COUNTER_DOWN_EN to add the up_dn direction input.
module bcd_tick_counter
  import bcd_counter_pkg::*;
#(
  parameter int DIV    = 1000,
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clr,
`ifdef BCD_TICK_COUNTER_DOWN_EN
  input  logic                    up_dn,
`endif
  output logic [BCD_W*DIGITS-1:0] bcd,
  output logic                    tick,
  output logic                    carry
);

  localparam int PS_W = clog2(DIV);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(DIV - 1);

  logic [PS_W-1:0]   ps_q;
  logic [PS_W-1:0]   ps_d;
  logic              tick_q;
  logic              tick_d;
  logic              carry_q;
  logic              carry_d;
  logic              wrap_evt;
  logic [DIGITS:0]   chain;
  logic [DIGITS-1:0] c_out;

`ifdef BCD_TICK_COUNTER_DOWN_EN
  logic dn;
  assign dn = ~up_dn;
`endif

  assign wrap_evt = en && (ps_q == PS_LAST);

  // chain[k] is the increment strobe for decade k; chain[DIGITS] means full wrap.
  assign chain[0] = wrap_evt;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    bcd_digit u_digit (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .inc   (chain[gi]),
`ifdef BCD_TICK_COUNTER_DOWN_EN
      .dn    (dn),
`endif
      .digit (bcd[gi*BCD_W +: BCD_W]),
      .c_out (c_out[gi])
    );
    assign chain[gi+1] = chain[gi] & c_out[gi];
  end

  always_comb begin
    ps_d    = ps_q;
    tick_d  = 1'b0;
    carry_d = 1'b0;
    if (clr) begin
      ps_d = '0;
    end else if (wrap_evt) begin
      ps_d    = '0;
      tick_d  = 1'b1;
      carry_d = chain[DIGITS];
    end else if (en) begin
      ps_d = ps_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ps_q    <= '0;
      tick_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      ps_q    <= ps_d;
      tick_q  <= tick_d;
      carry_q <= carry_d;
    end
  end

  assign tick  = tick_q;
  assign carry = carry_q;

endmodule

// File: doc/bcd_tick_counter.md
Name: bcd_tick_counter

Overview:
Downstream consumer stage for the free-running binary up counter. It turns raw clock cycles into an enabled, prescaled tick stream and counts those ticks in packed BCD (DIGITS decades), so the result can drive display or timing logic directly. A one-cycle carry pulse marks decade-chain wrap, which allows cascading.

Parameters:
DIV, 1000, prescale ratio: one BCD increment per DIV enabled clock cycles (legal range 1 to 2^23).
DIGITS, 4, number of BCD decades (legal range 1 to 8).

Ports:
clk  input  1  single clock; all state on the rising edge.
rst  input  1  asynchronous, active-low reset (rst=0 resets immediately, no clock edge needed).
en  input  1  count enable; prescaler advances only while en=1.
clr  input  1  synchronous clear.
bcd  output  4*DIGITS  packed BCD count; digit 0 in bits [3:0].
tick  output  1  one-cycle pulse, registered, high the cycle after each increment edge.
carry  output  1  one-cycle pulse, registered, high with the tick that wrapped all digits to 0.

Behaviour:
- Reset (rst=0, asynchronous): prescaler=0, bcd=0, tick=0, carry=0. Held while rst=0.
- Internal prescaler width is clog2(DIV), minimum 1. It counts 0..DIV-1.
- wrap_evt = en && (prescaler == DIV-1).
- Priority per rising edge: rst, then clr, then wrap_evt, then en, then hold.
- clr=1: prescaler=0, bcd=0, tick=0, carry=0. clr overrides a coincident wrap_evt, so no tick is produced.
- wrap_evt:
  - prescaler becomes 0.
  - tick becomes 1.
  - bcd increments by decimal ripple: digit k increments only if all lower digits are 9; a digit at 9 rolls to 0.
  - carry becomes 1 only if every digit was 9 (for DIGITS=4, 9999 goes to 0000).
- en=1 with no wrap_evt: prescaler increments; tick=0, carry=0.
- en=0: prescaler and bcd hold; tick=0, carry=0. Deasserting en mid-period keeps the partial count.
- DIV=1: wrap_evt fires every enabled cycle, so tick stays high continuously while en=1.
- Latency: bcd, tick and carry all change on the same edge as wrap_evt. There is no combinational path from inputs to outputs.
- Digit values A to F are unreachable. No check is required, but the increment cell maps any digit value of 9 or above to 0.

Optional Feature:
Macro: BCD_TICK_COUNTER_DOWN_EN.
- Defined:
  - Adds port "up_dn  input  1" (1 = up, 0 = down), sampled on the wrap_evt edge.
  - Counting down, a digit at 0 borrows: it becomes 9 and the next digit decrements.
  - All digits at 0 going down wraps to all 9s, with carry=1 on that tick.
- Undefined: no up_dn port; up-count only, exactly as above.

Decomposition:
- Package bcd_counter_pkg holds:
  - BCD_W = 4
  - BCD_MAX = 4'd9
  - BCD_ZERO = 4'd0
  - function clog2 for prescaler width.
- Sub-module bcd_digit: one decade cell with inputs clk, rst, clr, inc, (dn), and outputs digit[3:0] and c_out (combinational, asserted when digit is at its terminal value).
- The top instantiates DIGITS copies in a generate loop. inc of cell k = wrap_evt AND c_out of cells 0..k-1.

Test Plan (DIV=4, DIGITS=2 unless stated):
1. rst=0 for 10 cycles, then rst=1 with en=0 for 100 cycles -> bcd=8'h00 throughout, tick=0, carry=0.
2. en=1 for 40 cycles after reset -> tick pulses on cycles 4, 8, ..., 40 (one cycle each) and bcd=8'h10 at the end. Dropping en for 3 cycles mid-period then resuming -> next tick is delayed by exactly 3 cycles.
3. Run to bcd=8'h99, then let one more wrap_evt occur -> bcd=8'h00, with tick=1 and carry=1 on the same single cycle; the next tick has carry=0.
4. clr=1 asserted on the exact cycle of a wrap_evt at bcd=8'h37 -> next cycle bcd=8'h00, tick=0, prescaler=0; the first tick after that arrives 4 enabled cycles later.
5. rst pulled low asynchronously between clock edges while bcd=8'h52 -> bcd=0, tick=0 and carry=0 before the next edge; counting resumes from 0 after release.
6. With BCD_TICK_COUNTER_DOWN_EN defined, up_dn=0 from bcd=8'h00 -> after one wrap_evt bcd=8'h99 with carry=1. At 8'h10, the next tick gives 8'h09.
